// File: rtl/serial_operand_serializer.sv
//------------------------------------------------------------------------------
// Module   : serial_operand_serializer
// Purpose  : Parallel-to-serial transmitter for bit-serial operand pairs.
//            Accepts two W-bit operands over valid/ready and emits them one
//            bit per downstream transfer on two lockstep lines with
//            first/last frame markers.
// Options  : SERIALIZER_LSB_FIRST_EN - emit least significant bit first
//            (default build emits most significant bit first).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_operand_serializer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         up_valid,
  output logic         up_ready,
  input  logic [W-1:0] up_a,
  input  logic [W-1:0] up_b,
  output logic         ser_valid,
  input  logic         ser_ready,
  output logic         ser_a,
  output logic         ser_b,
  output logic         ser_first,
  output logic         ser_last
);

  // Counter needs at least one bit even for single-bit words.
  localparam int CW = (W > 1) ? $clog2(W) : 1;
  localparam logic [CW-1:0] c_LAST_IDX = CW'(W - 1);

`ifdef SERIALIZER_LSB_FIRST_EN
  localparam int c_TAP = 0;
`else
  localparam int c_TAP = W - 1;
`endif

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SHIFT = 1'b1
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [W-1:0]  r_sh_a, r_sh_b, w_sh_a_nxt, w_sh_b_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic          r_first, r_last, w_first_nxt, w_last_nxt;
  logic          w_up_xfer, w_dn_xfer;

  // Outputs come straight from flops; the shift registers are cleared when
  // idle so the data lines read 0 whenever ser_valid is low.
  assign ser_valid = (r_state == S_SHIFT);
  assign ser_a     = r_sh_a[c_TAP];
  assign ser_b     = r_sh_b[c_TAP];
  assign ser_first = r_first;
  assign ser_last  = r_last;

  // Accept a new pair when idle, or in the same cycle the last bit leaves.
  assign up_ready  = (r_state == S_IDLE) || (ser_valid && r_last && ser_ready);
  assign w_up_xfer = up_valid && up_ready;
  assign w_dn_xfer = ser_valid && ser_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  // Next-state and datapath: load has priority, then shift or drain on a bit transfer.
  always_comb begin
    w_state_nxt = r_state;
    w_sh_a_nxt  = r_sh_a;
    w_sh_b_nxt  = r_sh_b;
    w_cnt_nxt   = r_cnt;
    w_first_nxt = r_first;
    w_last_nxt  = r_last;
    if (w_up_xfer) begin
      w_state_nxt = S_SHIFT;
      w_sh_a_nxt  = up_a;
      w_sh_b_nxt  = up_b;
      w_cnt_nxt   = '0;
      w_first_nxt = 1'b1;
      w_last_nxt  = (W == 1);
    end else if (w_dn_xfer) begin
      if (r_last) begin
        w_state_nxt = S_IDLE;
        w_sh_a_nxt  = '0;
        w_sh_b_nxt  = '0;
        w_cnt_nxt   = '0;
        w_first_nxt = 1'b0;
        w_last_nxt  = 1'b0;
      end else begin
`ifdef SERIALIZER_LSB_FIRST_EN
        w_sh_a_nxt  = r_sh_a >> 1;
        w_sh_b_nxt  = r_sh_b >> 1;
`else
        w_sh_a_nxt  = r_sh_a << 1;
        w_sh_b_nxt  = r_sh_b << 1;
`endif
        w_cnt_nxt   = w_cnt_inc;
        w_first_nxt = 1'b0;
        w_last_nxt  = (w_cnt_inc == c_LAST_IDX);
      end
    end
  end

  // State and datapath registers; reset discards any word in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_sh_a  <= '0;
      r_sh_b  <= '0;
      r_cnt   <= '0;
      r_first <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sh_a  <= w_sh_a_nxt;
      r_sh_b  <= w_sh_b_nxt;
      r_cnt   <= w_cnt_nxt;
      r_first <= w_first_nxt;
      r_last  <= w_last_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_operand_serializer.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_operand_serializer
// Purpose  : Directed, table-driven bench for serial_operand_serializer
//            (W=8 and W=1 instances). Honours SERIALIZER_LSB_FIRST_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_operand_serializer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  // W = 8 instance
  logic       up_valid = 1'b0;
  logic       up_ready;
  logic [7:0] up_a = '0;
  logic [7:0] up_b = '0;
  logic       ser_valid;
  logic       ser_ready = 1'b1;
  logic       ser_a, ser_b, ser_first, ser_last;

  // W = 1 instance
  logic       up_valid1 = 1'b0;
  logic       up_ready1;
  logic [0:0] up_a1 = '0;
  logic [0:0] up_b1 = '0;
  logic       ser_valid1;
  logic       ser_ready1 = 1'b1;
  logic       ser_a1, ser_b1, ser_first1, ser_last1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_operand_serializer #(.W(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid),
    .up_ready  (up_ready),
    .up_a      (up_a),
    .up_b      (up_b),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .ser_a     (ser_a),
    .ser_b     (ser_b),
    .ser_first (ser_first),
    .ser_last  (ser_last)
  );

  serial_operand_serializer #(.W(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .up_valid  (up_valid1),
    .up_ready  (up_ready1),
    .up_a      (up_a1),
    .up_b      (up_b1),
    .ser_valid (ser_valid1),
    .ser_ready (ser_ready1),
    .ser_a     (ser_a1),
    .ser_b     (ser_b1),
    .ser_first (ser_first1),
    .ser_last  (ser_last1)
  );

  // Expected streams written as 8-bit strings: leftmost bit is sent first.
  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] sa_msb;
    logic [7:0] sb_msb;
    logic [7:0] sa_lsb;
    logic [7:0] sb_lsb;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic exp_seq(input vec_t v, output logic [7:0] sa, output logic [7:0] sb);
`ifdef SERIALIZER_LSB_FIRST_EN
    sa = v.sa_lsb;
    sb = v.sb_lsb;
`else
    sa = v.sa_msb;
    sb = v.sb_msb;
`endif
  endtask

  task automatic load8(input logic [7:0] a, input logic [7:0] b);
    int k = 0;
    while (!up_ready && k < 50) begin
      step();
      k++;
    end
    chk("up_ready_before_load", {31'd0, up_ready}, 32'd1);
    up_valid = 1'b1;
    up_a     = a;
    up_b     = b;
    step();
    up_valid = 1'b0;
    up_a     = ~a;   // must not affect the captured word
    up_b     = ~b;
  endtask

  task automatic check_word(input string tag, input logic [7:0] sa, input logic [7:0] sb);
    for (int i = 0; i < 8; i++) begin
      chk({tag, "_valid"}, {31'd0, ser_valid}, 32'd1);
      chk({tag, "_a"},     {31'd0, ser_a},     {31'd0, sa[7-i]});
      chk({tag, "_b"},     {31'd0, ser_b},     {31'd0, sb[7-i]});
      chk({tag, "_first"}, {31'd0, ser_first}, {31'd0, (i == 0)});
      chk({tag, "_last"},  {31'd0, ser_last},  {31'd0, (i == 7)});
      chk({tag, "_upready"}, {31'd0, up_ready}, {31'd0, (i == 7)});
      step();
    end
    chk({tag, "_idle_valid"}, {31'd0, ser_valid}, 32'd0);
    chk({tag, "_idle_outs"}, {28'd0, ser_a, ser_b, ser_first, ser_last}, 32'd0);
  endtask

  initial begin
    logic [7:0] sa, sb;
    int idx;
    logic stalled;

    vecs[0] = '{a:8'hD2, b:8'h4B, sa_msb:8'b11010010, sb_msb:8'b01001011,
                sa_lsb:8'b01001011, sb_lsb:8'b11010010};
    vecs[1] = '{a:8'hFF, b:8'h00, sa_msb:8'b11111111, sb_msb:8'b00000000,
                sa_lsb:8'b11111111, sb_lsb:8'b00000000};
    vecs[2] = '{a:8'h81, b:8'h7E, sa_msb:8'b10000001, sb_msb:8'b01111110,
                sa_lsb:8'b10000001, sb_lsb:8'b01111110};
    vecs[3] = '{a:8'h01, b:8'h80, sa_msb:8'b00000001, sb_msb:8'b10000000,
                sa_lsb:8'b10000000, sb_lsb:8'b00000001};
    vecs[4] = '{a:8'hC4, b:8'h35, sa_msb:8'b11000100, sb_msb:8'b00110101,
                sa_lsb:8'b00100011, sb_lsb:8'b10101100};
    vecs[5] = '{a:8'h4B, b:8'hD2, sa_msb:8'b01001011, sb_msb:8'b11010010,
                sa_lsb:8'b11010010, sb_lsb:8'b01001011};

    // Reset state
    step();
    step();
    chk("rst_valid",   {31'd0, ser_valid}, 32'd0);
    chk("rst_outs",    {28'd0, ser_a, ser_b, ser_first, ser_last}, 32'd0);
    chk("rst_upready", {31'd0, up_ready}, 32'd1);
    chk("rst_valid1",  {31'd0, ser_valid1}, 32'd0);
    rst = 1'b0;
    step();

    // Table-driven single words
    for (int v = 0; v < 6; v++) begin
      exp_seq(vecs[v], sa, sb);
      load8(vecs[v].a, vecs[v].b);
      check_word($sformatf("vec%0d", v), sa, sb);
    end

    // Back-to-back: D2/4B then 4B/D2 with up_valid held
    exp_seq(vecs[0], sa, sb);
    up_valid = 1'b1;
    up_a     = 8'hD2;
    up_b     = 8'h4B;
    chk("b2b_upready0", {31'd0, up_ready}, 32'd1);
    step();
    up_a = 8'h4B;
    up_b = 8'hD2;
    for (int i = 0; i < 16; i++) begin
      int j;
      j = i % 8;
      chk("b2b_valid", {31'd0, ser_valid}, 32'd1);
      chk("b2b_a", {31'd0, ser_a}, {31'd0, (i < 8) ? sa[7-j] : sb[7-j]});
      chk("b2b_b", {31'd0, ser_b}, {31'd0, (i < 8) ? sb[7-j] : sa[7-j]});
      chk("b2b_first", {31'd0, ser_first}, {31'd0, (j == 0)});
      chk("b2b_last",  {31'd0, ser_last},  {31'd0, (j == 7)});
      chk("b2b_upready", {31'd0, up_ready}, {31'd0, (j == 7)});
      step();
      if (i == 7) up_valid = 1'b0;
    end
    chk("b2b_end_valid", {31'd0, ser_valid}, 32'd0);

    // Backpressure: stall 3 cycles while bit 3 is presented
    load8(8'hD2, 8'h4B);
    idx = 0;
    for (int c = 0; c < 11; c++) begin
      stalled   = (c >= 3 && c < 6);
      ser_ready = !stalled;
      chk("bp_valid", {31'd0, ser_valid}, 32'd1);
      chk("bp_a", {31'd0, ser_a}, {31'd0, sa[7-idx]});
      chk("bp_b", {31'd0, ser_b}, {31'd0, sb[7-idx]});
      chk("bp_first", {31'd0, ser_first}, {31'd0, (idx == 0)});
      chk("bp_last",  {31'd0, ser_last},  {31'd0, (idx == 7)});
      chk("bp_upready", {31'd0, up_ready}, {31'd0, (!stalled && idx == 7)});
      step();
      if (!stalled) idx++;
    end
    ser_ready = 1'b1;
    chk("bp_end_valid", {31'd0, ser_valid}, 32'd0);

    // Reset while bit 4 is presented
    load8(8'hD2, 8'h4B);
    for (int i = 0; i < 4; i++) step();
    chk("mid_bit4_a", {31'd0, ser_a}, {31'd0, sa[3]});
    chk("mid_bit4_b", {31'd0, ser_b}, {31'd0, sb[3]});
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mid_rst_valid",   {31'd0, ser_valid}, 32'd0);
    chk("mid_rst_outs",    {28'd0, ser_a, ser_b, ser_first, ser_last}, 32'd0);
    chk("mid_rst_upready", {31'd0, up_ready}, 32'd1);
    step();
    chk("mid_rst_stays_idle", {31'd0, ser_valid}, 32'd0);
    load8(8'hD2, 8'h4B);
    check_word("after_rst", sa, sb);

    // Reset overrides a simultaneous upstream transfer
    up_valid = 1'b1;
    up_a     = 8'hFF;
    up_b     = 8'hFF;
    rst      = 1'b1;
    step();
    rst      = 1'b0;
    up_valid = 1'b0;
    chk("rst_ovr_valid",   {31'd0, ser_valid}, 32'd0);
    chk("rst_ovr_upready", {31'd0, up_ready}, 32'd1);
    step();
    chk("rst_ovr_idle", {31'd0, ser_valid}, 32'd0);

    // W = 1: single-bit frames
    for (int t = 0; t < 2; t++) begin
      up_valid1 = 1'b1;
      up_a1     = (t == 0) ? 1'b1 : 1'b0;
      up_b1     = (t == 0) ? 1'b0 : 1'b1;
      chk("w1_upready_idle", {31'd0, up_ready1}, 32'd1);
      step();
      up_valid1 = 1'b0;
      up_a1     = ~up_a1;
      up_b1     = ~up_b1;
      chk("w1_valid", {31'd0, ser_valid1}, 32'd1);
      chk("w1_a", {31'd0, ser_a1}, {31'd0, (t == 0)});
      chk("w1_b", {31'd0, ser_b1}, {31'd0, (t != 0)});
      chk("w1_first", {31'd0, ser_first1}, 32'd1);
      chk("w1_last",  {31'd0, ser_last1},  32'd1);
      chk("w1_upready_last", {31'd0, up_ready1}, 32'd1);
      step();
      chk("w1_idle_valid", {31'd0, ser_valid1}, 32'd0);
      chk("w1_idle_outs", {28'd0, ser_a1, ser_b1, ser_first1, ser_last1}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
